// File: rtl/up_to_59_elapsed_timer.sv
// mm:ss elapsed-time counter in BCD (00:00..59:59) gated by a start/stop/clear FSM.
// WRAP=0 saturates at 59:59 in DONE; WRAP=1 rolls over to 00:00 with a one-cycle pulse.

module up_to_59_digit #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  assign carry = inc && (value == MAXV);

  // Anything at or above MAX (including illegal codes) returns to 0 on increment.
  always_ff @(posedge clock) begin
    if (reset || clr)  value <= '0;
    else if (inc)      value <= (value >= MAXV) ? '0 : value + 1'b1;
  end
endmodule

module up_to_59_elapsed_timer #(
  parameter bit WRAP = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_units,
  output logic [2:0] sec_tens,
  output logic [3:0] min_units,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       done,
  output logic       rollover
);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t state, state_nxt;
  logic   all_max, hold, inc_en;
  logic   su_c, st_c, mu_c, mt_c;
  logic   rollover_q;

  assign all_max = (sec_units == 4'd9) && (sec_tens == 3'd5) &&
                   (min_units == 4'd9) && (min_tens == 3'd5);
  // In saturating mode the terminal tick must leave the digits at 59:59.
  assign hold    = !WRAP && all_max;
  assign inc_en  = (state == RUNNING) && tick && !stop && !clear && !hold;

  always_comb begin
    state_nxt = state;
    if (clear) state_nxt = IDLE;
    else begin
      case (state)
        IDLE, PAUSED: if (start) state_nxt = RUNNING;
        RUNNING: begin
          if (stop)                 state_nxt = PAUSED;
          else if (tick && hold)    state_nxt = DONE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) rollover_q <= 1'b0;
    else                rollover_q <= WRAP && mt_c;
  end

  up_to_59_digit #(.W(4), .MAX(9)) u_su (.clock(clock), .reset(reset), .clr(clear),
    .inc(inc_en), .value(sec_units), .carry(su_c));
  up_to_59_digit #(.W(3), .MAX(5)) u_st (.clock(clock), .reset(reset), .clr(clear),
    .inc(su_c),   .value(sec_tens),  .carry(st_c));
  up_to_59_digit #(.W(4), .MAX(9)) u_mu (.clock(clock), .reset(reset), .clr(clear),
    .inc(st_c),   .value(min_units), .carry(mu_c));
  up_to_59_digit #(.W(3), .MAX(5)) u_mt (.clock(clock), .reset(reset), .clr(clear),
    .inc(mu_c),   .value(min_tens),  .carry(mt_c));

  assign running  = (state == RUNNING);
  assign done     = !WRAP && (state == DONE);
  assign rollover = rollover_q;
endmodule

// File: tb/tb_up_to_59_elapsed_timer.sv
// Drives a saturating and a wrapping timer with identical directed stimulus and checks
// both every cycle against an elapsed-seconds model, plus literal spot checks.

module tb_up_to_59_elapsed_timer;
  logic clock = 1'b0;
  logic reset = 1'b1, tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] su0, mu0, su1, mu1;
  logic [2:0] st0, mt0, st1, mt1;
  logic run0, done0, roll0, run1, done1, roll1;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  // Model: elapsed seconds plus a mode per instance (0 idle, 1 running, 2 paused, 3 done).
  int m_cnt[2], m_mode[2];
  bit m_roll[2];

  always #5 clock = ~clock;

  up_to_59_elapsed_timer #(.WRAP(1'b0)) dut0 (.clock(clock), .reset(reset), .tick(tick),
    .start(start), .stop(stop), .clear(clear), .sec_units(su0), .sec_tens(st0),
    .min_units(mu0), .min_tens(mt0), .running(run0), .done(done0), .rollover(roll0));
  up_to_59_elapsed_timer #(.WRAP(1'b1)) dut1 (.clock(clock), .reset(reset), .tick(tick),
    .start(start), .stop(stop), .clear(clear), .sec_units(su1), .sec_tens(st1),
    .min_units(mu1), .min_tens(mt1), .running(run1), .done(done1), .rollover(roll1));

  always @(posedge clock) begin
    for (int w = 0; w < 2; w++) begin
      if (reset || clear) begin
        m_cnt[w] = 0; m_mode[w] = 0; m_roll[w] = 0;
      end else begin
        m_roll[w] = 0;
        if (m_mode[w] == 0 || m_mode[w] == 2) begin
          if (start) m_mode[w] = 1;
        end else if (m_mode[w] == 1) begin
          if (stop) m_mode[w] = 2;
          else if (tick) begin
            if (m_cnt[w] == 3599) begin
              if (w == 1) begin m_cnt[w] = 0; m_roll[w] = 1; end
              else m_mode[w] = 3;
            end else m_cnt[w] = m_cnt[w] + 1;
          end
        end
      end
    end
  end

  function automatic logic [16:0] model_vec(int w);
    int c = m_cnt[w];
    return {1'(m_mode[w] == 1), 1'(m_mode[w] == 3), m_roll[w],
            3'(c / 600), 4'((c / 60) % 10), 3'((c / 10) % 6), 4'(c % 10)};
  endfunction

  function automatic logic [16:0] dut_vec(int w);
    if (w == 0) return {run0, done0, roll0, mt0, mu0, st0, su0};
    return {run1, done1, roll1, mt1, mu1, st1, su1};
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      for (int w = 0; w < 2; w++) begin
        n_total++;
        if (dut_vec(w) === model_vec(w)) n_pass++;
        else $display("FAIL cycle_cmp dut%0d t=%0t got {run,done,roll,mm:ss}=%h expected %h",
                      w, $time, dut_vec(w), model_vec(w));
      end
    end
  end

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask

  // Digits as 0xMMSS-style BCD for literal checks.
  function automatic logic [15:0] bcd(int w);
    if (w == 0) return {1'b0, mt0, mu0, 1'b0, st0, su0};
    return {1'b0, mt1, mu1, 1'b0, st1, su1};
  endfunction

  task automatic step(logic t, logic s, logic p, logic c, logic r);
    tick = t; start = s; stop = p; clear = c; reset = r;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 1);
    lit("reset_digits", bcd(0), 16'h0000);
    lit("reset_flags",  {run0, done0, roll0, run1, roll1}, 0);

    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);            // lands in the same step as the start release
    ticks(4);
    lit("five_ticks", bcd(0), 16'h0005);
    lit("five_running", run0, 1);

    ticks(2);
    step(1, 0, 1, 0, 0);            // stop+tick: paused, tick dropped
    lit("stop_tick_hold", bcd(0), 16'h0007);
    lit("stop_tick_paused", run0, 0);
    ticks(3);
    lit("paused_ticks", bcd(0), 16'h0007);
    step(1, 1, 0, 0, 0);            // start+tick: running, tick dropped
    lit("start_tick_hold", {run0, 16'(bcd(0))}, {1'b1, 16'h0007});
    ticks(1);
    lit("resume_tick", bcd(0), 16'h0008);

    ticks(1);
    lit("at_0009", bcd(0), 16'h0009);
    ticks(1);
    lit("sec_carry", bcd(0), 16'h0010);
    ticks(49);
    ticks(1);
    lit("min_carry", bcd(0), 16'h0100);
    ticks(694);
    lit("at_1234", bcd(1), 16'h1234);

    step(1, 0, 0, 0, 1);            // reset beats tick mid-count
    lit("reset_mid", {bcd(0), 16'(bcd(1))}, 0);
    lit("reset_mid_flags", {run0, done0, run1, roll1}, 0);

    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);            // start+stop while running: stop wins
    lit("stop_beats_start", {run0, run1}, 0);
    step(0, 1, 0, 0, 0);
    ticks(3599);
    lit("at_5959", bcd(0), 16'h5959);
    ticks(1);
    lit("sat_digits", bcd(0), 16'h5959);
    lit("sat_flags", {run0, done0, roll0}, 3'b010);
    lit("wrap_digits", bcd(1), 16'h0000);
    lit("wrap_flags", {run1, done1, roll1}, 3'b101);
    step(0, 0, 0, 0, 0);
    lit("wrap_pulse_once", roll1, 0);
    step(1, 1, 0, 0, 0);
    lit("done_ignores_start", {done0, 16'(bcd(0))}, {1'b1, 16'h5959});
    step(0, 1, 0, 1, 0);            // clear beats start
    lit("clear_idle", {run0, done0, 16'(bcd(0))}, 0);

    step(0, 1, 0, 0, 0);
    ticks(3599);
    step(1, 0, 0, 1, 0);            // clear with terminal tick
    lit("clear_terminal", {done0, roll1, run0, run1, 16'(bcd(1))}, 0);
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
